multibyte_add_seq: RTL and testbench
====================================

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, meaning operand width in bytes (legal range 2..16).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have the port op_a, input, 8*NBYTES bits: operand A, unsigned, LSB byte at [7:0].
REQ-007 The block SHALL have the port op_b, input, 8*NBYTES bits: operand B.
REQ-008 The block SHALL have the port op_cin, input, 1 bit: initial carry-in.
REQ-009 The block SHALL have the port add_a, output, 8 bits: byte of A driven to the external 8-bit adder.
REQ-010 The block SHALL have the port add_b, output, 8 bits: byte of B driven to the external adder.
REQ-011 The block SHALL have the port add_cin, output, 1 bit: carry driven to the external adder.
REQ-012 The block SHALL have the port add_sum, input, 8 bits: sum returned by the external adder (combinational, same cycle).
REQ-013 The block SHALL have the port add_cout, input, 1 bit: carry-out returned by the external adder.
REQ-014 The block SHALL have the port out_valid, output, 1 bit: result is available.
REQ-015 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-016 The block SHALL have the port result, output, 8*NBYTES bits: the full sum.
REQ-017 The block SHALL have the port result_cout, output, 1 bit: final carry-out (unsigned overflow).
REQ-018 The block SHALL have the port result_ovf, output, 1 bit: two's-complement overflow of the NBYTES-wide add.
REQ-019 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-021 in_ready SHALL be high only in IDLE; an accept occurs on an edge where in_valid and in_ready are both high.
REQ-022 On accept, the block SHALL register op_a, op_b into internal registers, load carry_reg with op_cin, clear byte index idx to 0, and go to RUN.
REQ-023 In RUN, add_a and add_b SHALL be byte idx of the registered A and B, and add_cin SHALL be carry_reg, all driven combinationally from registers.
REQ-024 On each RUN edge, the block SHALL write add_sum into result byte idx, load carry_reg with add_cout, and increment idx.
REQ-025 When idx = NBYTES-1 on a RUN edge, the block SHALL also go to DONE, with result_cout = add_cout and result_ovf = add_cout XOR (the carry into bit 8*NBYTES-1).
REQ-026 The carry into the MSB SHALL be computed as add_a[7] XOR add_b[7] XOR add_sum[7] on the final byte.
REQ-027 Latency SHALL be exactly NBYTES cycles from the accept edge to the first cycle with out_valid high.
REQ-028 out_valid SHALL be high only in DONE; result, result_cout and result_ovf SHALL stay stable while out_valid is high.
REQ-029 On an edge in DONE with out_ready high, the block SHALL go to IDLE; a new accept SHALL then be possible no earlier than the next edge.
REQ-030 While out_ready is low, DONE SHALL hold indefinitely.
REQ-031 Outside RUN, add_a, add_b and add_cin SHALL be 0.
REQ-032 Changes on op_a, op_b, op_cin and in_valid after accept SHALL have no effect until the next accept.
REQ-033 Throughput SHALL be one operation per NBYTES+2 cycles when out_ready is held high.

Reset
REQ-034 When rst_n is low at an edge, the block SHALL enter IDLE from any state, including mid-RUN and DONE, abandoning any operation in progress without producing out_valid.
REQ-035 Reset values SHALL be: state IDLE; idx 0; carry_reg 0; result 0; result_cout 0; result_ovf 0; out_valid 0; busy 0; in_ready 1 from the first cycle after reset.

Verification
REQ-036 The bench SHALL cover, with NBYTES=4: op_a=0x0000_0001, op_b=0x0000_0002, op_cin=0 -> result=0x0000_0003, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-037 The bench SHALL cover a carry ripple through all bytes: op_a=0xFFFF_FFFF, op_b=0x0000_0000, op_cin=1 -> result=0x0000_0000, cout=1, ovf=0.
REQ-038 The bench SHALL cover signed overflow: op_a=0x7FFF_FFFF, op_b=0x0000_0001, op_cin=0 -> result=0x8000_0000, cout=0, ovf=1.
REQ-039 The bench SHALL cover backpressure: out_ready held low for 10 cycles in DONE -> result stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-040 The bench SHALL cover reset mid-RUN: rst_n low at the 2nd RUN edge -> IDLE, out_valid never asserted, a new operation then completes correctly.
REQ-041 The bench SHALL cover random back-to-back operations with out_ready=1 and an 8-bit adder model -> every result equals (a+b+cin) mod 2^32, and throughput is 6 cycles per operation.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: byte-serial multi-byte adder sequencing an external 8-bit adder
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_cin,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                result_cout,
  output logic                result_ovf,
  output logic                busy
);
  localparam int W  = 8*NBYTES;
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;
  logic          last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign last      = idx == IW'(NBYTES-1);
  always_comb begin
    add_a   = state == RUN ? a_reg[8*idx +: 8] : 8'd0;
    add_b   = state == RUN ? b_reg[8*idx +: 8] : 8'd0;
    add_cin = state == RUN ? carry_reg : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      result_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= op_a;
          b_reg     <= op_b;
          carry_reg <= op_cin;
          idx       <= '0;
          state     <= RUN;
        end
        RUN: begin
          result[8*idx +: 8] <= add_sum;
          carry_reg          <= add_cout;
          idx                <= idx + IW'(1);
          if (last) begin
            state       <= DONE;
            result_cout <= add_cout;
            // carry into the MSB recovered from the top bit of the final byte
            result_ovf  <= add_cout ^ add_a[7] ^ add_b[7] ^ add_sum[7];
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: randomized self-checking bench against an arithmetic reference
module tb_multibyte_add_seq;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_cin;
  logic [31:0] op_a, op_b, result;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, out_valid, out_ready, result_cout, result_ovf, busy;
  logic [8:0]  s9;
  int          checks = 0;
  int          errors = 0;
  time         acc_t, prev_t;

  always #5 clk = ~clk;

  assign s9 = add_a + add_b + add_cin;
  assign add_sum  = s9[7:0];
  assign add_cout = s9[8];

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .result_ovf(result_ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input int hold);
    logic [32:0] usum;
    longint      ssum;
    logic        ovf;
    int          n;
    usum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    ssum = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    op_a = a;
    op_b = b;
    op_cin = cin;
    in_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
    check("run_add_a", 64'(add_a), 64'(a[7:0]));
    check("run_add_b", 64'(add_b), 64'(b[7:0]));
    check("run_add_cin", 64'(add_cin), 64'(cin));
    check("run_busy", 64'(busy), 64'd1);
    op_a = $urandom;
    op_b = $urandom;
    op_cin = 1'($urandom);
    in_valid = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'd4);
    check("result", 64'(result), 64'(usum[31:0]));
    check("cout", 64'(result_cout), 64'(usum[32]));
    check("ovf", 64'(result_ovf), 64'(ovf));
    check("done_add", 64'({add_a, add_b, add_cin}), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_result", 64'({result_cout, result_ovf, result}), 64'({usum[32], ovf, usum[31:0]}));
    end
    out_ready = 1'b1;
    tick();
    check("idle_ready", 64'(in_ready), 64'd1);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'({out_valid, busy}), 64'd0);
    check("rst_result", 64'({result_cout, result_ovf, result}), 64'd0);
    check("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10);
    // abort mid-RUN: reset sampled on the second RUN edge
    op_a = 32'h0F0F_0F0F;
    op_b = 32'hF0F0_F0F0;
    op_cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'({result_cout, result_ovf, result}), 64'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        seen |= out_valid;
        tick();
      end
      check("abort_no_valid", 64'(seen), 64'd0);
    end
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      prev_t = acc_t;
      run_op($urandom, $urandom, 1'($urandom), 0);
      if (i > 0) check("throughput", 64'((acc_t - prev_t) / 10), 64'd6);
    end
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
